// File: rtl/dmem_access_ctrl_if.sv
// Requester-side bus of dmem_access_ctrl: request/op/address/store data in, grant/completion/load data out.
interface dmem_access_ctrl_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, op, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, op, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_access_ctrl.sv
// Two-port arbiter/sequencer in front of a byte-wide data memory; words are split into four MSB-first byte beats.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: r0 always wins ties (no round-robin pointer).
module dmem_access_ctrl #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_access_ctrl_if.slave        r0,
  dmem_access_ctrl_if.slave        r1,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wbyte,
  input  logic [DATA_WIDTH-1:0]    mem_rbyte,
  output logic                     busy
);

  localparam int AW = ADDRESS_WIDTH;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_SB  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [1:0]      cnt_r;
  logic [1:0]      cnt_nxt_s;
  logic [2:0]      op_r;
  logic [AW-1:0]   base_r;
  logic [31:0]     wdata_r;
  logic [31:0]     shift_r;
  logic            owner_r;

  logic            any_req_s;
  logic            win_s;
  logic            grant_s;
  logic [2:0]      sel_op_s;
  logic [31:0]     sel_addr_s;
  logic [31:0]     sel_wdata_s;
  logic            last_beat_s;
  logic [31:0]     result_s;
  logic            unused_s;

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] op, input logic [31:0] word);
    logic [31:0] res;
    case (op)
      OP_LW:   res = word;
      OP_LB:   res = {{24{word[7]}}, word[7:0]};
      OP_LBU:  res = {24'h000000, word[7:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Upper address bits beyond the array are ignored by design.
  assign unused_s = ^{r0.addr[31:AW], r1.addr[31:AW]};

  assign any_req_s = r0.req | r1.req;
  // Gating with rst_n keeps gnt low while reset is asserted even if requests are held.
  assign grant_s   = (state_r == ST_IDLE) && any_req_s && rst_n;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Winner select: r0 has absolute priority.
  always_comb begin
    if (r0.req) begin
      win_s = 1'b0;
    end else if (r1.req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end
`else
  logic prio_r;  // port favoured on the next tie

  // Winner select: ties go to the port not granted last.
  always_comb begin
    if (r0.req && r1.req) begin
      win_s = prio_r;
    end else if (r1.req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Round-robin pointer, moved only when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (grant_s) begin
      prio_r <= ~win_s;
    end
  end
`endif

  // Mux the winning requester's command.
  always_comb begin
    if (win_s) begin
      sel_op_s    = r1.op;
      sel_addr_s  = r1.addr;
      sel_wdata_s = r1.wdata;
    end else begin
      sel_op_s    = r0.op;
      sel_addr_s  = r0.addr;
      sel_wdata_s = r0.wdata;
    end
  end

  assign last_beat_s = is_word(op_r) ? (cnt_r == 2'd3) : 1'b1;

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: IDLE -> XFER (N beats) -> RESP -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_XFER;
          cnt_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (last_beat_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r + 2'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 2'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  // Command latch at grant; load bytes shift in MSB first during XFER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r <= 1'b0;
      op_r    <= 3'b000;
      base_r  <= '0;
      wdata_r <= 32'h0000_0000;
      shift_r <= 32'h0000_0000;
    end else if (grant_s) begin
      owner_r <= win_s;
      op_r    <= sel_op_s;
      base_r  <= is_word(sel_op_s) ? {sel_addr_s[AW-1:2], 2'b00} : sel_addr_s[AW-1:0];
      wdata_r <= sel_wdata_s;
      shift_r <= 32'h0000_0000;
    end else if ((state_r == ST_XFER) && is_load(op_r)) begin
      shift_r <= {shift_r[23:0], mem_rbyte};
    end
  end

  // Memory port drive; address wraps naturally at the array size.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wbyte = '0;
    if (state_r == ST_XFER) begin
      mem_addr = base_r + {{(AW-2){1'b0}}, cnt_r};
      mem_we   = is_store(op_r);
      if (op_r == OP_SW) begin
        case (cnt_r)
          2'd0:    mem_wbyte = wdata_r[31:24];
          2'd1:    mem_wbyte = wdata_r[23:16];
          2'd2:    mem_wbyte = wdata_r[15:8];
          2'd3:    mem_wbyte = wdata_r[7:0];
          default: mem_wbyte = '0;
        endcase
      end else if (op_r == OP_SB) begin
        mem_wbyte = wdata_r[7:0];
      end else begin
        mem_wbyte = '0;
      end
    end else begin
      mem_addr = '0;
    end
  end

  assign result_s = format_load(op_r, shift_r);

  // Requester handshakes and response data.
  always_comb begin
    r0.gnt    = grant_s & ~win_s;
    r1.gnt    = grant_s &  win_s;
    r0.rvalid = 1'b0;
    r1.rvalid = 1'b0;
    r0.rdata  = 32'h0000_0000;
    r1.rdata  = 32'h0000_0000;
    if (state_r == ST_RESP) begin
      if (owner_r) begin
        r1.rvalid = 1'b1;
        r1.rdata  = result_s;
      end else begin
        r0.rvalid = 1'b1;
        r0.rdata  = result_s;
      end
    end else begin
      r0.rvalid = 1'b0;
    end
  end

  assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, multi-cycle corner sequences, random traffic vs a byte-array model.
module tb_dmem_access_ctrl;

  localparam int AW    = 10;
  localparam int MEMSZ = 1024;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_SB  = 3'b011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wbyte;
  logic [7:0]    mem_rbyte;
  logic          busy;
  logic          mem_clear;

  logic [7:0] mem     [0:MEMSZ-1];
  logic [7:0] ref_mem [0:MEMSZ-1];

  int checks = 0;
  int errors = 0;
  int last_gnt = 1;

  always #5 clk = ~clk;

  dmem_access_ctrl_if r0_if ();
  dmem_access_ctrl_if r1_if ();

  dmem_access_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0        (r0_if),
    .r1        (r1_if),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wbyte (mem_wbyte),
    .mem_rbyte (mem_rbyte),
    .busy      (busy)
  );

  // Byte-wide array: combinational read, write on posedge.
  assign mem_rbyte = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wbyte;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      r0_if.req = req; r0_if.op = op; r0_if.addr = addr; r0_if.wdata = wdata;
    end else begin
      r1_if.req = req; r1_if.op = op; r1_if.addr = addr; r1_if.wdata = wdata;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) r0_if.req = 1'b0;
    else        r1_if.req = 1'b0;
  endtask

  function automatic logic [3:0] hs();
    return {r1_if.rvalid, r0_if.rvalid, r1_if.gnt, r0_if.gnt};
  endfunction

  function automatic logic get_gnt(input int p);
    return (p == 0) ? r0_if.gnt : r1_if.gnt;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? r0_if.rdata : r1_if.rdata;
  endfunction

  // Packed view of every output: busy, we, wbyte, addr, handshakes, rdata-nonzero flags.
  function automatic logic [31:0] outs_vec();
    return {6'd0, busy, mem_we, mem_wbyte, mem_addr, hs(), |r1_if.rdata, |r0_if.rdata};
  endfunction

  function automatic bit word_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Reference model: executes one transaction on ref_mem with plain byte arithmetic.
  task automatic ref_exec(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int a;
    logic [7:0] b;
    a = int'(addr % 32'd1024);
    if (word_op(op)) a = a - (a % 4);
    b = ref_mem[a];
    rdata = 32'h0;
    case (op)
      OP_LW:  for (int k = 0; k < 4; k++) rdata = (rdata << 8) | {24'h0, ref_mem[(a + k) % MEMSZ]};
      OP_LB:  rdata = b[7] ? (32'hFFFF_FF00 | {24'h0, b}) : {24'h0, b};
      OP_LBU: rdata = {24'h0, b};
      OP_SW:  for (int k = 0; k < 4; k++) ref_mem[(a + k) % MEMSZ] = 8'(wdata >> (24 - 8 * k));
      OP_SB:  ref_mem[a] = wdata[7:0];
      default: rdata = 32'h0;
    endcase
  endtask

  // Waits for port p's grant (req already raised), then follows its beats and response.
  task automatic serve(input int p, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] got);
    int w, beats, base, exp_addr;
    logic exp_we;
    logic [7:0] exp_wb;
    logic [31:0] exp_rd, act;
    got = 32'h0;
    w = 0;
    @(negedge clk);
    while (!get_gnt(p) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("grant wait", w, 0);
    if (!get_gnt(p)) begin
      drop_req(p);
      return;
    end
    check("grant exclusive", {31'd0, get_gnt(1 - p)}, 32'd0);
    last_gnt = p;
    ref_exec(op, addr, wdata, exp_rd);
    beats  = word_op(op) ? 4 : 1;
    base   = int'(addr % 32'd1024);
    if (word_op(op)) base = base - (base % 4);
    exp_we = (op == OP_SW) || (op == OP_SB);
    @(posedge clk);
    #1 drop_req(p);
    for (int k = 0; k < beats; k++) begin
      @(negedge clk);
      exp_addr = (base + k) % MEMSZ;
      exp_wb   = (op == OP_SW) ? 8'(wdata >> (24 - 8 * k)) : (exp_we ? wdata[7:0] : 8'h00);
      act = outs_vec();
      act[23:16] = act[23:16] & {8{mem_we}};
      check("beat", act, {6'd0, 1'b1, exp_we, exp_wb, 10'(exp_addr), 4'b0000, 2'b00});
    end
    @(negedge clk);
    check("resp handshake", {28'd0, hs()}, (p == 0) ? 32'h4 : 32'h8);
    got = get_rdata(p);
    check("resp rdata", got, exp_rd);
    check("resp other rdata", get_rdata(1 - p), 32'h0);
    check("resp busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic single(input int p, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    @(posedge clk);
    #1 set_port(p, 1'b1, op, addr, wdata);
    serve(p, op, addr, wdata, got);
  endtask

  task automatic pair(input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] w0,
                      input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] w1);
    int win;
    logic [31:0] got;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    win = 0;
`else
    win = (last_gnt == 0) ? 1 : 0;
`endif
    @(posedge clk);
    #1;
    set_port(0, 1'b1, op0, a0, w0);
    set_port(1, 1'b1, op1, a1, w1);
    if (win == 0) begin
      serve(0, op0, a0, w0, got);
      serve(1, op1, a1, w1, got);
    end else begin
      serve(1, op1, a1, w1, got);
      serve(0, op0, a0, w0, got);
    end
  endtask

  typedef struct {
    int          port;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [31:0] got, addr, wdata;
    logic [2:0]  op;
    int exp_port, mism;

    vecs[0]  = '{0, OP_SW,    32'h0000_0105, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{0, OP_LW,    32'h0000_0104, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1, OP_LB,    32'h0000_0106, 32'h0,         32'hFFFF_FFBE};
    vecs[3]  = '{0, OP_LBU,   32'h0000_0106, 32'h0,         32'h0000_00BE};
    vecs[4]  = '{1, OP_LB,    32'h0000_0105, 32'h0,         32'hFFFF_FFAD};
    vecs[5]  = '{0, OP_LW,    32'hFFFF_F107, 32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{0, OP_LW,    32'h0000_03FC, 32'h0,         32'h0000_0000};
    vecs[7]  = '{1, OP_SB,    32'h0000_03FF, 32'h1234_567A, 32'h0000_0000};
    vecs[8]  = '{0, OP_LB,    32'h0000_03FF, 32'h0,         32'h0000_007A};
    vecs[9]  = '{1, OP_LW,    32'h0000_03FE, 32'h0,         32'h0000_007A};
    vecs[10] = '{0, 3'b111,   32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{1, OP_LBU,   32'h0000_0010, 32'h0,         32'h0000_0000};
    vecs[12] = '{0, 3'b100,   32'h0000_0104, 32'h5555_5555, 32'h0000_0000};
    vecs[13] = '{1, OP_LW,    32'h0000_0104, 32'h0,         32'hDEAD_BEEF};
    vecs[14] = '{0, OP_SW,    32'h0000_020A, 32'h80FF_0011, 32'h0000_0000};
    vecs[15] = '{1, OP_LB,    32'h0000_0208, 32'h0,         32'hFFFF_FF80};
    vecs[16] = '{0, OP_LBU,   32'h0000_020B, 32'h0,         32'h0000_0011};

    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'h00;

    // Reset with both requesters already asking for lbu.
    mem_clear = 1'b1;
    set_port(0, 1'b1, OP_LBU, 32'h104, 32'h0);
    set_port(1, 1'b1, OP_LBU, 32'h106, 32'h0);
    repeat (3) @(negedge clk);
    check("reset outputs", outs_vec(), 32'h0);
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    rst_n     = 1'b1;

    // Contention from reset: one grant every 3 cycles, owner alternating (or always r0).
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = (c / 3) % 2;
`endif
      if (c % 3 == 0)      check("contention handshake", {28'd0, hs()}, 32'd1 << exp_port);
      else if (c % 3 == 2) check("contention handshake", {28'd0, hs()}, 32'd4 << exp_port);
      else                 check("contention handshake", {28'd0, hs()}, 32'd0);
    end
`ifdef DMEM_ARB_FIXED_PRIO_EN
    last_gnt = 0;
`else
    last_gnt = 1;
`endif
    @(posedge clk);
    #1;
    drop_req(0);
    drop_req(1);

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      single(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata, got);
      check("vector rdata", got, vecs[i].exp_rdata);
    end

    // Reset in the middle of a word store: two bytes land, no response.
    single(0, OP_SW, 32'h200, 32'hCAFE_F00D, got);
    @(posedge clk);
    #1 set_port(0, 1'b1, OP_SW, 32'h200, 32'h1122_3344);
    @(negedge clk);
    check("abort grant", {28'd0, hs()}, 32'h1);
    @(posedge clk);
    #1 drop_req(0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort outputs", outs_vec(), 32'h0);
    ref_mem[12'h200] = 8'h11;
    ref_mem[12'h201] = 8'h22;
    last_gnt = 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("abort idle", {27'd0, busy, hs()}, 32'h0);
    end
    check("abort byte 200", {24'd0, mem[12'h200]}, 32'h11);
    check("abort byte 201", {24'd0, mem[12'h201]}, 32'h22);
    check("abort byte 202", {24'd0, mem[12'h202]}, 32'hF0);
    check("abort byte 203", {24'd0, mem[12'h203]}, 32'h0D);

    // Random single and contending traffic against the model.
    for (int i = 0; i < 60; i++) begin
      op    = 3'($urandom_range(0, 7));
      wdata = $urandom();
      addr  = ($urandom_range(0, 3) == 0) ? (32'h3FC + $urandom_range(0, 3)) : $urandom();
      if ($urandom_range(0, 2) == 0) begin
        pair(op, addr, wdata, 3'($urandom_range(0, 7)), $urandom(), $urandom());
      end else begin
        single(int'($urandom_range(0, 1)), op, addr, wdata, got);
      end
    end

    @(negedge clk);
    mism = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("memory image", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
